mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single main-memory port between the I-cache refill engine and the D-cache refill/write-back engine.
- Each grant is one line-sized burst of LINE_WORDS word transfers, sequenced by an FSM and a word counter.
- Generates the pipeline stall request for the control unit.
- Contains a per-word watchdog that aborts a burst when memory hangs.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, word width
- LINE_WORDS, 4, words per burst (power of 2, ≥2)
- TIMEOUT, 15, max cycles waiting for mem_ready per word before abort (≤255)

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- ic_req  in  1  I-cache line refill request, held until ic_done
- ic_addr  in  ADDR_W  I-cache miss address
- ic_rvalid  out  1  refill word valid
- ic_rdata  out  DATA_W  refill word
- ic_widx  out  log2(LINE_WORDS)  index of current word
- ic_done  out  1  one-cycle burst-complete pulse
- dc_req  in  1  D-cache request, held until dc_done
- dc_we  in  1  1 = line write-back, 0 = refill; held with dc_req
- dc_addr  in  ADDR_W  D-cache line address
- dc_wdata  in  DATA_W  write word selected by dc_widx (combinational from cache)
- dc_rvalid  out  1  refill word valid
- dc_rdata  out  DATA_W  refill word
- dc_widx  out  log2(LINE_WORDS)  index of current word
- dc_done  out  1  one-cycle burst-complete pulse
- mem_req  out  1  word access request
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  word byte address
- mem_wdata  out  DATA_W  write data
- mem_ready  in  1  word accepted / read data valid this cycle
- mem_rdata  in  DATA_W  read data
- stall  out  1  to control unit: freeze pipeline
- err  out  1  sticky timeout flag

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, DONE.
- Reset (async, any state, including mid-burst):
  - State goes to IDLE; counters and last_grant clear (last_grant = I).
  - All outputs go to 0 immediately.
- IDLE:
  - Only ic_req set → BUSY_I. Only dc_req set → BUSY_D.
  - Both set → grant the requester opposite last_grant (round-robin), so D wins the first tie after reset.
  - Grant registers base = addr with the low log2(LINE_WORDS)+2 bits cleared, sets widx = 0, and updates last_grant.
- BUSY_x:
  - mem_req = 1.
  - mem_addr = {base[ADDR_W-1:log2(LINE_WORDS)+2], widx, 2'b00}.
  - mem_we = dc_we for BUSY_D, 0 for BUSY_I; mem_wdata = dc_wdata.
- On mem_ready in BUSY_x:
  - Read burst: x_rvalid = 1 and x_rdata = mem_rdata in the same cycle, with x_widx = the word index.
  - widx increments; the watchdog clears.
  - Last word (widx = LINE_WORDS-1) → DONE.
- DONE:
  - x_done pulses for 1 cycle; mem_req = 0; next state is IDLE.
  - Minimum gap between bursts is therefore 2 cycles, one in DONE and one in IDLE.
- Requester rule: x_req is sampled only in IDLE.
  - Deassertion mid-burst is a protocol violation; the burst completes regardless.
  - A req still high in IDLE after done is treated as a new request, so the cache must drop req on done.
- Watchdog:
  - Counts the cycles in BUSY_x with mem_ready = 0.
  - Reaching TIMEOUT: err sets (sticky until reset), x_done pulses (through DONE), and no further words are issued.
- stall = (state != IDLE) || ic_req || dc_req. It is combinational so the CU freezes in the same cycle as the miss.
- Non-granted requester outputs (rvalid, done) stay 0 throughout.
- widx width: log2(LINE_WORDS); it wraps to 0 only on burst exit.

Decomposition:
- Shared constants package, added to the existing constants header:
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D, DONE}
  - grant_t enum {GNT_I, GNT_D}
  - default LINE_WORDS and TIMEOUT values
- One natural sub-module: arb_watchdog, a timeout counter with clear/enable inputs and an expire output.
- Everything else stays in mem_arbiter.

Test Plan:
- Reset, then ic_req=1, ic_addr=0x0000_1034, memory ready 2 cycles after each mem_req:
  - mem_addr sequence is 0x1030, 0x1034, 0x1038, 0x103C.
  - 4 ic_rvalid pulses with ic_widx 0..3.
  - ic_done arrives 1 cycle after the 4th word; stall high throughout.
- ic_req and dc_req rise in the same cycle after reset:
  - D burst runs first, then I.
  - Repeating the tie alternates the grant order.
- dc_req=1, dc_we=1, dc_addr=0x200, cache supplies word = 0xA0+idx:
  - mem_we=1 on all 4 words; mem_wdata is 0xA0..0xA3.
  - dc_rvalid stays 0; dc_done pulses once.
- Memory never asserts mem_ready:
  - After 15 cycles, err=1 and ic_done pulses.
  - State returns to IDLE; err stays 1 until nrst.
- nrst driven low mid-burst at word 2:
  - mem_req and stall go 0 asynchronously.
  - After release, a new ic_req starts again at widx 0.
- dc_req asserted during DONE of an I burst:
  - D is granted from IDLE 2 cycles after the I burst's last ready.
  - No overlap of mem_req between the two bursts.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types, defaults and the tie-break rule for the main-memory port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  localparam int LINE_WORDS_DEF = 4;
  localparam int TIMEOUT_DEF    = 15;

  // A lone requester always wins; on a tie the side not served last wins.
  function automatic grant_t rr_pick(input logic i_ic, input logic i_dc, input grant_t i_last);
    if (i_ic && i_dc) return (i_last == GNT_I) ? GNT_D : GNT_I;
    return i_dc ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Per-word memory watchdog: down-counter reloaded on clear, expires on the
// last enabled cycle before terminal count.
module arb_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int                CNT_W = 8;
  localparam logic [CNT_W-1:0]  LOAD  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= LOAD;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Fires on the TIMEOUT-th consecutive stalled cycle.
  assign o_expire = i_en && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory port between I-cache refill and D-cache refill/write-back,
// one line burst per grant, with a per-word hang watchdog.
//
// state  | meaning
// IDLE   | no burst; sample ic_req/dc_req and grant round-robin on a tie
// BUSY_I | I-cache refill burst, one word per mem_ready
// BUSY_D | D-cache refill or write-back burst, one word per mem_ready
// DONE   | one-cycle done pulse to the granted side, memory port quiet
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          ic_req,
  input  logic [ADDR_W-1:0]             ic_addr,
  output logic                          ic_rvalid,
  output logic [DATA_W-1:0]             ic_rdata,
  output logic [$clog2(LINE_WORDS)-1:0] ic_widx,
  output logic                          ic_done,
  input  logic                          dc_req,
  input  logic                          dc_we,
  input  logic [ADDR_W-1:0]             dc_addr,
  input  logic [DATA_W-1:0]             dc_wdata,
  output logic                          dc_rvalid,
  output logic [DATA_W-1:0]             dc_rdata,
  output logic [$clog2(LINE_WORDS)-1:0] dc_widx,
  output logic                          dc_done,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic                          mem_ready,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          stall,
  output logic                          err
);

  localparam int                IDX_W     = $clog2(LINE_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);

  arb_state_t        r_state;
  grant_t            r_last;
  logic [ADDR_W-1:0] r_base;
  logic [IDX_W-1:0]  r_widx;
  logic              r_err;

  logic   w_busy_i;
  logic   w_busy_d;
  logic   w_busy;
  logic   w_expire;
  grant_t w_pick;

  assign w_busy_i = (r_state == BUSY_I);
  assign w_busy_d = (r_state == BUSY_D);
  assign w_busy   = w_busy_i || w_busy_d;
  assign w_pick   = rr_pick(ic_req, dc_req, r_last);

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .nrst     (nrst),
    .i_clr    (!w_busy || mem_ready),
    .i_en     (w_busy && !mem_ready),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_last  <= GNT_I;
      r_base  <= '0;
      r_widx  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ic_req || dc_req) begin
            r_state <= (w_pick == GNT_D) ? BUSY_D : BUSY_I;
            r_last  <= w_pick;
            r_base  <= ((w_pick == GNT_D) ? dc_addr : ic_addr) & ~LINE_MASK;
            r_widx  <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready) begin
            r_widx <= r_widx + IDX_W'(1);
            if (r_widx == LAST_IDX) r_state <= DONE;
          end else if (w_expire) begin
            r_err   <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_widx  <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req   = w_busy;
  assign mem_we    = w_busy_d && dc_we;
  assign mem_addr  = w_busy ? (r_base | ADDR_W'({r_widx, 2'b00})) : '0;
  assign mem_wdata = w_busy ? dc_wdata : '0;

  assign ic_rvalid = w_busy_i && mem_ready;
  assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
  assign ic_widx   = w_busy_i ? r_widx : '0;
  assign ic_done   = (r_state == DONE) && (r_last == GNT_I);

  assign dc_rvalid = w_busy_d && mem_ready && !dc_we;
  assign dc_rdata  = dc_rvalid ? mem_rdata : '0;
  assign dc_widx   = w_busy_d ? r_widx : '0;
  assign dc_done   = (r_state == DONE) && (r_last == GNT_D);

  // Combinational so the pipeline freezes in the miss cycle; held low while in reset.
  assign stall = nrst && ((r_state != IDLE) || ic_req || dc_req);
  assign err   = r_err;

endmodule
